// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetcher: req/ack fetches into a DEPTH-entry FIFO, flushed on redirect.
// Define IPQ_PERF_CNT_EN to add the saturating perf_redirects / perf_starve counters.
module inst_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             halted,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             consume,
    output logic [XLEN-1:0]  inst,
    output logic [XLEN-1:0]  inst_addr,
    output logic             inst_valid,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [0:3][7:0]  imem_rdata
`ifdef IPQ_PERF_CNT_EN
    ,
    output logic [15:0]      perf_redirects,
    output logic [15:0]      perf_starve
`endif
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t          state;
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [XLEN-1:0] addr_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   next_rd;
    logic [CW-1:0]   count;
    logic [CW-1:0]   remain;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] word;
    logic            enq;
    logic            deq;
    logic            issue;

    assign word       = {imem_rdata[3], imem_rdata[2], imem_rdata[1], imem_rdata[0]};
    assign inst_valid = (count != '0);
    assign enq        = (state == WAIT) && imem_ack && !redirect;
    assign deq        = consume && inst_valid && !redirect;
    // Issue is gated on a free slot now, so the eventual ack can always be stored.
    assign issue      = (state == IDLE) && !halted && !redirect && (count < DEPTH_C);
    assign remain     = count - CW'(deq);
    assign next_rd    = rd_ptr + AW'(deq);

    always_ff @(posedge clk) begin
        if (enq) begin
            data_mem[wr_ptr] <= word;
            addr_mem[wr_ptr] <= imem_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            inst      <= '0;
            inst_addr <= '0;
        end else begin
            // A raised request is held until its ack, even across redirect or halt.
            case (state)
                IDLE: begin
                    if (issue) begin
                        state     <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                        if (!redirect) begin
                            fetch_pc <= fetch_pc + XLEN'(4);
                        end
                    end else if (redirect) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase

            if (redirect) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (enq) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                rd_ptr <= next_rd;
                count  <= count + CW'(enq) - CW'(deq);
                // The head registers follow the entry that will be at the front next cycle.
                if (enq && (remain == '0)) begin
                    inst      <= word;
                    inst_addr <= imem_addr;
                end else if (deq && (remain != '0)) begin
                    inst      <= data_mem[next_rd];
                    inst_addr <= addr_mem[next_rd];
                end
            end
        end
    end

`ifdef IPQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            perf_redirects <= '0;
            perf_starve    <= '0;
        end else begin
            if (redirect && (perf_redirects != 16'hFFFF)) begin
                perf_redirects <= perf_redirects + 16'd1;
            end
            if (!inst_valid && !halted && (perf_starve != 16'hFFFF)) begin
                perf_starve <= perf_starve + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_inst_prefetch_queue;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            halted;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            consume;
    logic [31:0]     inst;
    logic [31:0]     inst_addr;
    logic            inst_valid;
    logic            imem_req;
    logic [31:0]     imem_addr;
    logic            imem_ack;
    logic [0:3][7:0] imem_rdata;
`ifdef IPQ_PERF_CNT_EN
    logic [15:0]     perf_redirects;
    logic [15:0]     perf_starve;
`endif

    int pass_count  = 0;
    int check_count = 0;

    typedef struct {
        logic        consume;
        logic        ack;
        logic [31:0] word;
        logic        exp_valid;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;
        logic [31:0] exp_inst_addr;
    } vec_t;

    vec_t vecs [19];

    // Reference model: the FIFO is a pair of queues, plus one outstanding-request record.
    logic [31:0] mq_data [$];
    logic [31:0] mq_addr [$];
    logic [31:0] m_fpc;
    logic [31:0] m_req_addr;
    logic [31:0] m_inst;
    logic [31:0] m_inst_addr;
    logic [31:0] m_word;
    bit          m_pend;
    bit          m_drop;

    always #5 clk = ~clk;

    inst_prefetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .halted      (halted),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .consume     (consume),
        .inst        (inst),
        .inst_addr   (inst_addr),
        .inst_valid  (inst_valid),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata)
`ifdef IPQ_PERF_CNT_EN
        ,
        .perf_redirects (perf_redirects),
        .perf_starve    (perf_starve)
`endif
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic r, input logic [31:0] a,
                             input logic [31:0] i, input logic [31:0] ia);
        check_output({tag, ".valid"}, 32'(inst_valid), 32'(v));
        check_output({tag, ".req"}, 32'(imem_req), 32'(r));
        check_output({tag, ".imem_addr"}, imem_addr, a);
        check_output({tag, ".inst"}, inst, i);
        check_output({tag, ".inst_addr"}, inst_addr, ia);
    endtask

    task automatic apply_stimulus(input logic h, input logic r, input logic [31:0] rpc,
                                  input logic c, input logic a, input logic [31:0] w);
        halted        = h;
        redirect      = r;
        redirect_pc   = rpc;
        consume       = c;
        imem_ack      = a;
        m_word        = w;
        imem_rdata[0] = w[7:0];
        imem_rdata[1] = w[15:8];
        imem_rdata[2] = w[23:16];
        imem_rdata[3] = w[31:24];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic h, input logic r, input logic [31:0] rpc,
                         input logic c, input logic a, input logic [31:0] w);
        apply_stimulus(h, r, rpc, c, a, w);
        tick();
    endtask

    task automatic model_reset();
        mq_data.delete();
        mq_addr.delete();
        m_fpc       = 32'h0;
        m_req_addr  = 32'h0;
        m_inst      = 32'h0;
        m_inst_addr = 32'h0;
        m_pend      = 0;
        m_drop      = 0;
    endtask

    // Advances the model across one clock edge using the inputs currently applied.
    task automatic model_step();
        bit issue;
        issue = !m_pend && !halted && !redirect && (mq_data.size() < DEPTH);
        if (redirect) begin
            mq_data.delete();
            mq_addr.delete();
            m_fpc = redirect_pc & ~32'h3;
            if (m_pend) begin
                if (imem_ack) begin
                    m_pend = 0;
                    m_drop = 0;
                end else begin
                    m_drop = 1;
                end
            end
        end else begin
            if (consume && mq_data.size() > 0) begin
                void'(mq_data.pop_front());
                void'(mq_addr.pop_front());
            end
            if (m_pend && imem_ack) begin
                if (!m_drop) begin
                    mq_data.push_back(m_word);
                    mq_addr.push_back(m_req_addr);
                    m_fpc = m_fpc + 32'd4;
                end
                m_pend = 0;
                m_drop = 0;
            end
        end
        if (issue) begin
            m_pend     = 1;
            m_req_addr = m_fpc;
        end
        if (mq_data.size() > 0) begin
            m_inst      = mq_data[0];
            m_inst_addr = mq_addr[0];
        end
    endtask

    task automatic reset_dut();
        rst_b = 1'b0;
        apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        model_reset();
    endtask

    initial begin
        logic        h;
        logic        r;
        logic        c;
        logic        a;
        logic [31:0] rpc;
        logic [31:0] w;

        vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,  32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 32'h0,  32'h12345678, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,  32'h12345678, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h11110004, 1'b1, 1'b0, 32'h4,  32'h12345678, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,  32'h12345678, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'h22220008, 1'b1, 1'b0, 32'h8,  32'h12345678, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,  32'h12345678, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h3333000C, 1'b1, 1'b0, 32'hC,  32'h12345678, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,  32'h12345678, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,  32'h12345678, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,  32'h11110004, 32'h4};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10, 32'h11110004, 32'h4};
        vecs[12] = '{1'b0, 1'b1, 32'h44440010, 1'b1, 1'b0, 32'h10, 32'h11110004, 32'h4};
        vecs[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h10, 32'h22220008, 32'h8};
        vecs[14] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h14, 32'h3333000C, 32'hC};
        vecs[15] = '{1'b1, 1'b1, 32'h55550014, 1'b1, 1'b0, 32'h14, 32'h44440010, 32'h10};
        vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h18, 32'h55550014, 32'h14};
        vecs[17] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h18, 32'h55550014, 32'h14};
        vecs[18] = '{1'b1, 1'b1, 32'h66660018, 1'b1, 1'b0, 32'h18, 32'h66660018, 32'h18};

        rst_b = 1'b0;
        apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0);
        model_reset();
        #3;
        check_all("reset", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;

        // Zero-wait fetch stream, fill to full, then consume-driven refill.
        for (int i = 0; i < 19; i++) begin
            cycle(0, 0, 32'h0, vecs[i].consume, vecs[i].ack, vecs[i].word);
            check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_req,
                      vecs[i].exp_addr, vecs[i].exp_inst, vecs[i].exp_inst_addr);
        end

        // Delayed ack with a redirect in the second wait cycle.
        reset_dut();
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        check_all("t3.issue", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        check_all("t3.wait1", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        cycle(0, 1, 32'h100, 0, 0, 32'h0);
        check_all("t3.redirect", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        check_all("t3.held", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        cycle(0, 0, 32'h0, 0, 1, 32'hDEADBEEF);
        check_all("t3.dropped", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        check_all("t3.refetch", 1'b0, 1'b1, 32'h100, 32'h0, 32'h0);
        cycle(0, 0, 32'h0, 0, 1, 32'hCAFE0100);
        check_all("t3.target", 1'b1, 1'b0, 32'h100, 32'hCAFE0100, 32'h100);

        // Redirect, consume and ack all in one cycle.
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        check_all("t4.issue", 1'b1, 1'b1, 32'h104, 32'hCAFE0100, 32'h100);
        cycle(0, 1, 32'h203, 1, 1, 32'hBAD0BAD0);
        check_all("t4.flush", 1'b0, 1'b0, 32'h104, 32'hCAFE0100, 32'h100);
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        check_all("t4.aligned", 1'b0, 1'b1, 32'h200, 32'hCAFE0100, 32'h100);
        cycle(0, 0, 32'h0, 0, 1, 32'h00C0FFEE);
        check_all("t4.fresh", 1'b1, 1'b0, 32'h200, 32'h00C0FFEE, 32'h200);

        // Halt during an outstanding request, then an async reset mid-request.
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        check_all("t5.issue", 1'b1, 1'b1, 32'h204, 32'h00C0FFEE, 32'h200);
        cycle(1, 0, 32'h0, 0, 0, 32'h0);
        check_all("t5.halt_wait", 1'b1, 1'b1, 32'h204, 32'h00C0FFEE, 32'h200);
        cycle(1, 0, 32'h0, 0, 1, 32'hABCD0204);
        check_all("t5.halt_ack", 1'b1, 1'b0, 32'h204, 32'h00C0FFEE, 32'h200);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 32'h0, 0, 0, 32'h0);
            check_output($sformatf("t5.halt_idle%0d.req", i), 32'(imem_req), 32'h0);
        end
        cycle(1, 0, 32'h0, 1, 0, 32'h0);
        check_all("t5.consume", 1'b1, 1'b0, 32'h204, 32'hABCD0204, 32'h204);
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        check_all("t5.resume", 1'b1, 1'b1, 32'h208, 32'hABCD0204, 32'h204);
        rst_b = 1'b0;
        #1;
        check_all("t5.async_reset", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        rst_b = 1'b1;

`ifdef IPQ_PERF_CNT_EN
        reset_dut();
        check_output("t6.redirects_reset", 32'(perf_redirects), 32'h0);
        check_output("t6.starve_reset", 32'(perf_starve), 32'h0);
        repeat (3) cycle(1, 1, 32'h40, 0, 0, 32'h0);
        repeat (10) cycle(0, 0, 32'h0, 0, 0, 32'h0);
        check_output("t6.redirects", 32'(perf_redirects), 32'd3);
        check_output("t6.starve", 32'(perf_starve), 32'd10);
        repeat (65540) cycle(0, 1, 32'h40, 0, 0, 32'h0);
        check_output("t6.redirects_sat", 32'(perf_redirects), 32'hFFFF);
        check_output("t6.starve_sat", 32'(perf_starve), 32'hFFFF);
`endif

        // Randomized traffic against the reference model, including redirects near the top of memory.
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            h   = ($urandom_range(0, 9) == 0);
            r   = ($urandom_range(0, 19) == 0);
            c   = 1'($urandom_range(0, 1));
            a   = m_pend && ($urandom_range(0, 4) < 2);
            rpc = ($urandom_range(0, 5) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF))
                                              : ($urandom & 32'hFFF);
            w   = $urandom;
            apply_stimulus(h, r, rpc, c, a, w);
            model_step();
            tick();
            check_all($sformatf("rand%0d", i), 1'(mq_data.size() > 0), 1'(m_pend),
                      m_req_addr, m_inst, m_inst_addr);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
